mac_accumulator: RTL and testbench



---
 rtl/mac_accumulator.sv | 115 +++++++++++
 tb/tb_mac_accumulator.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : mac_accumulator
// Summary  : sums TERMS consecutive products into one dot product and hands
//            the result out on a valid/ready port with a sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================

module mac_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int TERMS  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_overflow,
  output logic              busy
);

  localparam int CNT_W = (TERMS > 1) ? $clog2(TERMS) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TERMS - 1);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;

  logic             w_accept;
  logic             w_deliver;
  logic             w_first;
  logic             w_last;
  logic [ACC_W-1:0] w_base;
  logic [ACC_W:0]   w_sum;

  assign w_accept  = in_valid && in_ready;
  assign w_deliver = out_valid && out_ready;
  assign w_first   = (r_cnt == '0);
  assign w_last    = (r_cnt == C_LAST);

  // cnt is always zero in HOLD, so a zero-bubble accept starts a fresh sum.
  assign w_base = w_first ? '0 : r_acc;
  assign w_sum  = {1'b0, w_base} + {1'b0, ACC_W'(in_product)};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ACCUM: begin
        if (w_accept && w_last) begin
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_deliver) begin
          w_state_next = (w_accept && w_last) ? ST_HOLD : ST_ACCUM;
        end
      end
      default: w_state_next = ST_ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_ACCUM: in_ready = !clear;
      ST_HOLD: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if ((r_state == ST_ACCUM) && clear) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_sum[ACC_W-1:0];
      r_ovf <= (w_first ? 1'b0 : r_ovf) | w_sum[ACC_W];
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign out_sum      = r_acc;
  assign out_overflow = r_ovf;
  assign busy         = (r_state == ST_HOLD) || (r_cnt != '0);

endmodule

`default_nettype wire

// File: tb/tb_mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_accumulator
// Summary  : scoreboard bench; A (ACC_W=16) and B (ACC_W=9) share stimulus,
//            C (TERMS=1) streams on its own inputs.
// Revision : 1.0 - initial release
// ============================================================================

module tb_mac_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_product = '0;
  logic       clear = 1'b0;
  logic       out_ready = 1'b1;

  logic        in_ready_a, out_valid_a, out_overflow_a, busy_a;
  logic [15:0] out_sum_a;
  logic        in_ready_b, out_valid_b, out_overflow_b, busy_b;
  logic [8:0]  out_sum_b;

  logic        c_in_valid = 1'b0;
  logic [7:0]  c_in_product = '0;
  logic        c_out_ready = 1'b1;
  logic        in_ready_c, out_valid_c, out_overflow_c, busy_c;
  logic [15:0] out_sum_c;

  int checks = 0;
  int errors = 0;

  int exp_sum_a[$];
  int exp_ovf_a[$];
  int exp_sum_b[$];
  int exp_ovf_b[$];
  int exp_sum_c[$];

  always #5 clk = ~clk;

  mac_accumulator #(.PROD_W(8), .ACC_W(16), .TERMS(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_product(in_product), .clear(clear), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_sum(out_sum_a), .out_overflow(out_overflow_a),
    .busy(busy_a)
  );

  mac_accumulator #(.PROD_W(8), .ACC_W(9), .TERMS(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_product(in_product), .clear(clear), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_sum(out_sum_b), .out_overflow(out_overflow_b),
    .busy(busy_b)
  );

  mac_accumulator #(.PROD_W(8), .ACC_W(16), .TERMS(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(in_ready_c),
    .in_product(c_in_product), .clear(1'b0), .out_valid(out_valid_c),
    .out_ready(c_out_ready), .out_sum(out_sum_c), .out_overflow(out_overflow_c),
    .busy(busy_c)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus lives at posedge+1; checks happen on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] p);
    int n;
    n = 0;
    in_valid   = 1'b1;
    in_product = p;
    @(negedge clk);
    while (!in_ready_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 0, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic push_ab(input int sa, input int oa, input int sb, input int ob);
    exp_sum_a.push_back(sa);
    exp_ovf_a.push_back(oa);
    exp_sum_b.push_back(sb);
    exp_ovf_b.push_back(ob);
  endtask

  // Monitor: every delivery is matched against the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid_a && out_ready) begin
      if (exp_sum_a.size() == 0) chk("a_unexpected_result", 1, 0);
      else begin
        chk("a_sum", int'(out_sum_a), exp_sum_a.pop_front());
        chk("a_ovf", int'(out_overflow_a), exp_ovf_a.pop_front());
      end
    end
    if (rst_n && out_valid_b && out_ready) begin
      if (exp_sum_b.size() == 0) chk("b_unexpected_result", 1, 0);
      else begin
        chk("b_sum", int'(out_sum_b), exp_sum_b.pop_front());
        chk("b_ovf", int'(out_overflow_b), exp_ovf_b.pop_front());
      end
    end
    if (rst_n && out_valid_c && c_out_ready) begin
      if (exp_sum_c.size() == 0) chk("c_unexpected_result", 1, 0);
      else chk("c_sum", int'(out_sum_c), exp_sum_c.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    step();
    step();
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid_a), 0);
    chk("rst_out_sum", int'(out_sum_a), 0);
    chk("rst_out_ovf", int'(out_overflow_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready_a), 1);
    step();

    // Basic sum; B wraps: 900 mod 512 = 388 with overflow
    push_ab(900, 0, 388, 1);
    for (int i = 0; i < 4; i++) send(8'd225);
    @(negedge clk);
    chk("basic_out_valid", int'(out_valid_a), 1);
    chk("basic_busy_hold", int'(busy_a), 1);
    step();
    @(negedge clk);
    chk("basic_busy_after", int'(busy_a), 0);
    chk("basic_valid_after", int'(out_valid_a), 0);
    step();

    // Overflow must not leak into the next dot product
    push_ab(10, 0, 10, 0);
    for (int i = 1; i <= 4; i++) send(8'(i));
    step();

    // Backpressure, then zero-bubble handoff with product 7 first
    out_ready = 1'b0;
    push_ab(100, 0, 100, 0);
    send(8'd10); send(8'd20); send(8'd30); send(8'd40);
    in_valid   = 1'b1;
    in_product = 8'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready_a), 0);
      chk("bp_out_valid", int'(out_valid_a), 1);
      chk("bp_sum_stable_a", int'(out_sum_a), 100);
      chk("bp_sum_stable_b", int'(out_sum_b), 100);
      step();
    end
    out_ready = 1'b1;
    push_ab(34, 0, 34, 0);
    send(8'd7); send(8'd8); send(8'd9); send(8'd10);

    // clear in ACCUM drops the partial sum and the product offered with it
    push_ab(10, 0, 10, 0);
    send(8'd10); send(8'd20);
    clear      = 1'b1;
    in_valid   = 1'b1;
    in_product = 8'd99;
    @(negedge clk);
    chk("clr_in_ready", int'(in_ready_a), 0);
    chk("clr_busy_before", int'(busy_a), 1);
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("clr_busy_after", int'(busy_a), 0);
    step();
    send(8'd1); send(8'd2); send(8'd3);
    out_ready = 1'b0;
    send(8'd4);
    // clear in HOLD is ignored
    clear = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("clr_hold_valid", int'(out_valid_a), 1);
      chk("clr_hold_sum", int'(out_sum_a), 10);
      step();
    end
    clear     = 1'b0;
    out_ready = 1'b1;
    step();

    // Reset mid-accumulation drops the partial result
    send(8'd1); send(8'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", int'(busy_a), 0);
    chk("rst_mid_valid", int'(out_valid_a), 0);
    step();
    push_ab(4, 0, 4, 0);
    for (int i = 0; i < 4; i++) send(8'd1);
    step();
    step();

    // TERMS=1 streaming: one result per cycle, no bubbles
    exp_sum_c.push_back(5);
    exp_sum_c.push_back(6);
    exp_sum_c.push_back(7);
    for (int i = 0; i < 4; i++) begin
      c_in_valid   = (i < 3);
      c_in_product = 8'(5 + i);
      @(negedge clk);
      chk("c_in_ready", int'(in_ready_c), 1);
      if (i > 0) chk("c_out_valid", int'(out_valid_c), 1);
      step();
    end
    @(negedge clk);
    chk("c_valid_end", int'(out_valid_c), 0);
    step();
    step();

    chk("a_queue_empty", exp_sum_a.size(), 0);
    chk("b_queue_empty", exp_sum_b.size(), 0);
    chk("c_queue_empty", exp_sum_c.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
